// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers, data-memory port, write-back select, forwarding and retire count.
module mem_wb_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_aluout,
  input  logic [WIDTH-1:0] ex_writedata,
  input  logic [4:0]       ex_writereg,
  input  logic [WIDTH-1:0] ex_pcplus4,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_memwrite,
  input  logic             ex_jal,
  output logic             memwrite,
  output logic [WIDTH-1:0] memaddr,
  output logic [WIDTH-1:0] memwritedata,
  input  logic [WIDTH-1:0] memreaddata,
  input  logic             mem_ready,
  output logic             mem_stall,
  output logic             mem_fwd_en,
  output logic [4:0]       mem_fwd_reg,
  output logic [WIDTH-1:0] mem_fwd_data,
  output logic             mem_is_load,
  output logic             wb_regwrite,
  output logic [4:0]       wb_writereg,
  output logic [WIDTH-1:0] wb_result,
  output logic [31:0]      retired
);
  logic             m_valid, m_regwrite, m_memtoreg, m_memwrite, m_jal;
  logic [WIDTH-1:0] m_aluout, m_writedata, m_pcplus4, m_result;
  logic [4:0]       m_writereg;
  logic             w_valid, w_regwrite;
  logic [4:0]       w_writereg;
  logic [WIDTH-1:0] w_result;
  always_comb begin
    mem_stall    = m_valid & (m_memtoreg | m_memwrite) & ~mem_ready;
    memwrite     = m_valid & m_memwrite;
    memaddr      = m_aluout;
    memwritedata = m_writedata;
    m_result     = m_jal ? m_pcplus4 : m_memtoreg ? memreaddata : m_aluout;
    mem_fwd_en   = m_valid & m_regwrite & ~m_memtoreg & (m_writereg != 5'd0);
    mem_fwd_reg  = m_writereg;
    mem_fwd_data = m_result;
    mem_is_load  = m_valid & m_memtoreg;
    wb_regwrite  = w_valid & w_regwrite & (w_writereg != 5'd0);
    wb_writereg  = w_writereg;
    wb_result    = w_result;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid     <= 1'b0;
      m_regwrite  <= 1'b0;
      m_memtoreg  <= 1'b0;
      m_memwrite  <= 1'b0;
      m_jal       <= 1'b0;
      m_aluout    <= '0;
      m_writedata <= '0;
      m_pcplus4   <= '0;
      m_writereg  <= 5'd0;
    end else if (!mem_stall) begin
      m_valid     <= ex_valid;
      m_regwrite  <= ex_regwrite;
      m_memtoreg  <= ex_memtoreg;
      m_memwrite  <= ex_memwrite;
      m_jal       <= ex_jal;
      m_aluout    <= ex_aluout;
      m_writedata <= ex_writedata;
      m_pcplus4   <= ex_pcplus4;
      m_writereg  <= ex_writereg;
    end
  end
  // a stalled access sends a bubble down to WB while MEM holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_writereg <= 5'd0;
      w_result   <= '0;
    end else begin
      w_valid    <= m_valid & ~mem_stall;
      w_regwrite <= m_regwrite & ~mem_stall;
      w_writereg <= m_writereg;
      w_result   <= m_result;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired <= 32'd0;
    else if (w_valid) retired <= retired + 32'd1;
  end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed stimulus with an instruction-level model and write-back scoreboard.
module tb_mem_wb_pipe;
  typedef struct packed {
    logic        valid;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  wreg;
    logic        rw, mtr, mw, jal;
  } ins_t;
  typedef struct packed {
    logic        wr;
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_t;
  logic clk = 1'b0, reset = 1'b0;
  logic ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_jal, mem_ready;
  logic [31:0] ex_aluout, ex_writedata, ex_pcplus4, memreaddata;
  logic [4:0] ex_writereg;
  logic memwrite, mem_stall, mem_fwd_en, mem_is_load, wb_regwrite;
  logic [31:0] memaddr, memwritedata, mem_fwd_data, wb_result, retired;
  logic [4:0] mem_fwd_reg, wb_writereg;
  ins_t cur = '0;
  wb_t q[$];
  wb_t e;
  int checks = 0, errors = 0, sync_req = 0, sync_seen = 0;
  logic pwr = 1'b0;
  logic [4:0] preg = 5'd0;
  logic [31:0] pres = '0, pret = '0, r0;
  mem_wb_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_aluout(ex_aluout),
    .ex_writedata(ex_writedata), .ex_writereg(ex_writereg), .ex_pcplus4(ex_pcplus4),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_jal(ex_jal), .memwrite(memwrite), .memaddr(memaddr), .memwritedata(memwritedata),
    .memreaddata(memreaddata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .mem_is_load(mem_is_load), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
    .wb_result(wb_result), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  function automatic ins_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [4:0] r, input logic [31:0] p,
                              input logic rw, input logic mt, input logic mw, input logic j);
    mk = '{v, a, d, p, r, rw, mt, mw, j};
  endfunction
  function automatic logic [31:0] res(input ins_t i, input logic [31:0] rd);
    res = i.jal ? i.pc4 : i.mtr ? rd : i.alu;
  endfunction
  task automatic drive(input ins_t i);
    ex_valid = i.valid; ex_aluout = i.alu; ex_writedata = i.wd; ex_pcplus4 = i.pc4;
    ex_writereg = i.wreg; ex_regwrite = i.rw; ex_memtoreg = i.mtr;
    ex_memwrite = i.mw; ex_jal = i.jal;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic samp();
    @(negedge clk);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, 32'({memwrite, mem_stall, mem_fwd_en, mem_is_load, wb_regwrite, mem_fwd_reg, wb_writereg}), 32'd0);
    chk({n, "_memaddr"}, memaddr, 32'd0);
    chk({n, "_memwritedata"}, memwritedata, 32'd0);
    chk({n, "_fwd_data"}, mem_fwd_data, 32'd0);
    chk({n, "_wb_result"}, wb_result, 32'd0);
    chk({n, "_retired"}, retired, 32'd0);
  endtask
  // instruction leaves MEM unless it is an access still waiting on memory
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= '0;
      q.delete();
    end else if (!(cur.valid && (cur.mtr || cur.mw) && !mem_ready)) begin
      if (cur.valid) q.push_back('{cur.rw && cur.wreg != 5'd0, cur.wreg, res(cur, memreaddata)});
      cur <= '{ex_valid, ex_aluout, ex_writedata, ex_pcplus4, ex_writereg,
               ex_regwrite, ex_memtoreg, ex_memwrite, ex_jal};
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (sync_seen != sync_req) sync_seen <= sync_req;
      else if (retired == pret + 32'd1) begin
        chk("wb_retire_queued", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("wb_regwrite", 32'(pwr), 32'(e.wr));
          if (e.wr) begin
            chk("wb_writereg", 32'(preg), 32'(e.rg));
            chk("wb_result", pres, e.data);
          end
        end
      end else begin
        chk("retired_hold", retired, pret);
        chk("wb_regwrite_idle", 32'(pwr), 32'd0);
      end
      chk("mem_stall", 32'(mem_stall), 32'(cur.valid && (cur.mtr || cur.mw) && !mem_ready));
      chk("memwrite", 32'(memwrite), 32'(cur.valid && cur.mw));
      chk("memaddr", memaddr, cur.alu);
      chk("memwritedata", memwritedata, cur.wd);
      chk("mem_is_load", 32'(mem_is_load), 32'(cur.valid && cur.mtr));
      chk("mem_fwd_en", 32'(mem_fwd_en), 32'(cur.valid && cur.rw && !cur.mtr && cur.wreg != 5'd0));
      chk("mem_fwd_reg", 32'(mem_fwd_reg), 32'(cur.wreg));
      chk("mem_fwd_data", mem_fwd_data, res(cur, memreaddata));
      pret <= retired;
      pwr <= wb_regwrite;
      preg <= wb_writereg;
      pres <= wb_result;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, got running expected finished");
    $fatal(1);
  end
  initial begin
    drive('0);
    mem_ready = 1'b1;
    memreaddata = '0;
    #1 reset = 1'b1;
    #1 chk_zero("reset_init");
    repeat (2) tick();
    reset = 1'b0;
    sync_req++;
    tick();
    drive(mk(1, 32'h5, 0, 5'd3, 0, 1, 0, 0, 0));
    tick();
    drive(mk(1, 32'hF, 0, 5'd4, 0, 1, 0, 0, 0));
    samp();
    chk("alu_fwd_en", 32'(mem_fwd_en), 32'd1);
    chk("alu_fwd_data", mem_fwd_data, 32'h5);
    tick();
    drive('0);
    samp();
    chk("alu_wb1", 32'({wb_regwrite, wb_writereg}), 32'h23);
    chk("alu_wb1_data", wb_result, 32'h5);
    tick();
    samp();
    chk("alu_wb2", 32'({wb_regwrite, wb_writereg}), 32'h24);
    chk("alu_wb2_data", wb_result, 32'hF);
    tick();
    samp();
    chk("alu_retired", retired, 32'd2);
    r0 = retired;
    drive(mk(1, 32'h40, 0, 5'd8, 0, 1, 1, 0, 0));
    mem_ready = 1'b0;
    tick();
    drive('0);
    samp();
    chk("lw_stall1", 32'({mem_stall, mem_is_load, mem_fwd_en}), 32'b110);
    chk("lw_addr", memaddr, 32'h40);
    tick();
    samp();
    chk("lw_stall2", 32'({mem_stall, mem_is_load, wb_regwrite}), 32'b110);
    tick();
    mem_ready = 1'b1;
    memreaddata = 32'hDEADBEEF;
    samp();
    chk("lw_ready", 32'({mem_stall, mem_is_load, mem_fwd_en}), 32'b010);
    tick();
    memreaddata = '0;
    samp();
    chk("lw_wb", 32'({wb_regwrite, wb_writereg}), 32'h28);
    chk("lw_wb_data", wb_result, 32'hDEADBEEF);
    tick();
    samp();
    chk("lw_retired", retired, r0 + 32'd1);
    r0 = retired;
    drive(mk(1, 32'h80, 32'h1234, 5'd0, 0, 0, 0, 1, 0));
    mem_ready = 1'b0;
    tick();
    drive('0);
    samp();
    chk("sw_wait", 32'({memwrite, mem_stall}), 32'b11);
    chk("sw_wait_addr", memaddr, 32'h80);
    chk("sw_wait_data", memwritedata, 32'h1234);
    tick();
    mem_ready = 1'b1;
    samp();
    chk("sw_done", 32'({memwrite, mem_stall}), 32'b10);
    chk("sw_done_addr", memaddr, 32'h80);
    chk("sw_done_data", memwritedata, 32'h1234);
    tick();
    samp();
    chk("sw_wb", 32'({memwrite, wb_regwrite}), 32'b00);
    tick();
    samp();
    chk("sw_retired", retired, r0 + 32'd1);
    r0 = retired;
    drive(mk(1, 32'h999, 0, 5'd31, 32'h104, 1, 0, 0, 1));
    tick();
    drive(mk(1, 32'h7, 0, 5'd0, 0, 1, 0, 0, 0));
    samp();
    chk("jal_fwd", 32'({mem_fwd_en, mem_fwd_reg}), 32'h3F);
    chk("jal_fwd_data", mem_fwd_data, 32'h104);
    tick();
    drive('0);
    samp();
    chk("jal_wb", 32'({wb_regwrite, wb_writereg}), 32'h3F);
    chk("jal_wb_data", wb_result, 32'h104);
    chk("r0_fwd_en", 32'(mem_fwd_en), 32'd0);
    tick();
    samp();
    chk("r0_wb_regwrite", 32'(wb_regwrite), 32'd0);
    tick();
    samp();
    chk("jal_r0_retired", retired, r0 + 32'd2);
    tick();
    force dut.retired = 32'hFFFFFFFF;
    sync_req++;
    #1 release dut.retired;
    samp();
    chk("wrap_preload", retired, 32'hFFFFFFFF);
    drive(mk(1, 32'h1, 0, 5'd5, 0, 1, 0, 0, 0));
    tick();
    drive('0);
    tick();
    samp();
    chk("wrap_before", retired, 32'hFFFFFFFF);
    tick();
    samp();
    chk("wrap_after", retired, 32'd0);
    drive(mk(1, 32'hC0, 32'h55, 5'd0, 0, 0, 0, 1, 0));
    mem_ready = 1'b0;
    tick();
    drive('0);
    #2 chk("rst_sw_memwrite_before", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1 chk_zero("rst_mid");
    tick();
    tick();
    mem_ready = 1'b1;
    reset = 1'b0;
    sync_req++;
    tick();
    samp();
    chk("rst_after", 32'({memwrite, wb_regwrite}), 32'd0);
    chk("rst_after_retired", retired, 32'd0);
    tick();
    samp();
    chk("wb_pending", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Back half of the five-stage MIPS pipeline: the EX/MEM and MEM/WB pipeline registers, the data-memory port, write-back result selection and forwarding sources. It sits directly downstream of the ID/EX register and ALU, consuming the ALU result, store data and delayed control bits. It drives the register-file write port and returns a stall to the upstream stages while a data-memory access waits on `mem_ready`.

## Interface
- `WIDTH`, default 32: datapath width.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX stage holds a real instruction; 0 means bubble.
- `ex_aluout`  in  WIDTH  ALU result; this is the memory address for lw/sw.
- `ex_writedata`  in  WIDTH  store data (ID/EX rd2).
- `ex_writereg`  in  5  destination register after the regdst mux.
- `ex_pcplus4`  in  WIDTH  PC+4 of the instruction, used as the jal link value.
- `ex_regwrite`, `ex_memtoreg`, `ex_memwrite`, `ex_jal`  in  1 each  delayed control bits.
- `memwrite`  out  1  data-memory write strobe.
- `memaddr`  out  WIDTH  data-memory address.
- `memwritedata`  out  WIDTH  data-memory write data.
- `memreaddata`  in  WIDTH  data-memory read data; valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_stall`  out  1  hold IF/ID, ID/EX and PC this cycle.
- `mem_fwd_en`, `mem_fwd_reg`, `mem_fwd_data`  out  1/5/WIDTH  forwarding source from the MEM stage.
- `mem_is_load`  out  1  MEM stage holds a valid lw, for load-use detection.
- `wb_regwrite`, `wb_writereg`, `wb_result`  out  1/5/WIDTH  register-file write port.
- `retired`  out  32  count of instructions that have completed WB.

## Operation
**EX/MEM register**
- Captures all `ex_*` inputs on posedge clk when `mem_stall`=0.
- Holds its contents when `mem_stall`=1.

**Memory access**
- Access condition: `m_valid & (m_memtoreg | m_memwrite)`.
- `memaddr` = `m_aluout` and `memwritedata` = `m_writedata`, both combinational from the EX/MEM register.
- `memwrite` = `m_valid & m_memwrite`. It stays high on every cycle the store is held, until `mem_ready`.

**Stall**
- `mem_stall` = access condition & ~`mem_ready`.
- Non-memory instructions never stall.

**MEM result**
- `m_result` = `m_pcplus4` if `m_jal`.
- Otherwise `memreaddata` if `m_memtoreg`.
- Otherwise `m_aluout`.

**MEM/WB register**
- Captures every cycle.
- On `mem_stall`=1 it loads a bubble: valid=0, regwrite=0, and all other fields are don't-care.
- Otherwise it loads the EX/MEM valid bit, regwrite, writereg and `m_result`. The captured `memreaddata` is the value presented while `mem_ready`=1.

**Write-back**
- `wb_regwrite` = `w_valid & w_regwrite & (w_writereg != 0)`. Writes to $0 are suppressed.
- `wb_writereg` = `w_writereg`; `wb_result` = `w_result`.

**Forwarding**
- `mem_fwd_en` = `m_valid & m_regwrite & ~m_memtoreg & (m_writereg != 0)`.
- `mem_fwd_reg` = `m_writereg`; `mem_fwd_data` = `m_result`.
- Load data is never forwarded from MEM; the hazard unit stalls on `mem_is_load` instead.
- `mem_is_load` = `m_valid & m_memtoreg`.

**Retire counter**
- `retired` increments by 1 on each posedge where `w_valid`=1. Bubbles do not count.
- It wraps from 0xFFFFFFFF to 0.

**Simultaneous events**
- When `ex_valid`=1 arrives during `mem_stall`, the EX/MEM register ignores it. The upstream stage holds the instruction, so nothing is lost.

## Timing
**Reset**
- Reset is asynchronous: all valid bits, data fields and `retired` clear to 0 immediately on `reset`=1.
- During reset, every output is 0: `memwrite`, `mem_stall`, `mem_fwd_en`, `mem_is_load`, `wb_regwrite`, all buses, `retired`.
- Reset asserted mid-access abandons the access; `memwrite` drops within the same cycle.

**Latency**
- EX input to MEM outputs: 1 cycle.
- MEM to WB outputs: 1 cycle, plus N cycles when `mem_ready` is held low for N cycles.
- `mem_stall`, `memwrite`, `memaddr`, forwarding outputs and `mem_is_load` are combinational from registers and `mem_ready`. There is no path from `ex_*` inputs to any output.

**Memory handshake**
- An access completes on the first posedge with `mem_ready`=1.
- Zero-wait memory (`mem_ready` tied high) gives no stalls and full throughput of one instruction per cycle.
- `memaddr`, `memwritedata` and `memwrite` stay stable while stalled.

## Test plan
- **Reset during a store:** sw with `mem_ready`=0, then assert `reset` mid-cycle.
  - `memwrite` falls asynchronously; all outputs are 0 and `retired`=0.
- **Back-to-back ALU ops, zero-wait memory:** add writing $3=0x5, then or writing $4=0xF.
  - `wb_regwrite`=1 on cycles 2 and 3 with the correct reg/data.
  - `mem_fwd_en`=1 with data 0x5 in cycle 1.
  - `retired`=2.
- **Load with 2 wait states:** lw $8 at 0x40, `memreaddata`=0xDEADBEEF, `mem_ready` low for 2 cycles.
  - `mem_stall`=1 for exactly 2 cycles; `mem_is_load`=1 throughout.
  - Exactly one bubble-free WB of $8=0xDEADBEEF; `mem_fwd_en`=0.
- **Store with 1 wait state:** sw data 0x1234 at 0x80.
  - `memwrite`=1 for 2 cycles with a stable addr/data.
  - `wb_regwrite` stays 0; `retired` increments by 1.
- **jal plus write to $0:**
  - jal with `ex_pcplus4`=0x104 and writereg 31: WB writes $31=0x104.
  - addi to $0: `wb_regwrite`=0 and `mem_fwd_en`=0, but `retired` still increments.
- **Counter wrap:** force `retired` to 0xFFFFFFFF (via hierarchical preload), then retire 1 instruction.
  - `retired`=0.
